// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad definitions: entry states, default key codes, digit count
package keypad_pkg;

  localparam int DIGITS = 4;

  localparam logic [3:0] KEY_BSP = 4'hA;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_ENT = 4'hF;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ENTRY = 2'd1,
    S_FULL  = 2'd2
  } entry_state_t;

endpackage

// File: rtl/bcd4_to_bin.sv
// rtl/bcd4_to_bin.sv - combinational 4-digit BCD to 14-bit binary converter
module bcd4_to_bin (
  input  logic [15:0] bcd,
  output logic [13:0] bin
);

  logic [13:0] d3, d2, d1, d0;

  assign d3 = 14'(bcd[15:12]);
  assign d2 = 14'(bcd[11:8]);
  assign d1 = 14'(bcd[7:4]);
  assign d0 = 14'(bcd[3:0]);

  // Max 9999 fits in 14 bits, so no intermediate widening is needed.
  assign bin = d3 * 14'd1000 + d2 * 14'd100 + d1 * 14'd10 + d0;

endmodule

// File: rtl/key_entry_buffer.sv
// rtl/key_entry_buffer.sv - 4-digit keypad entry buffer with backspace, clear and commit
module key_entry_buffer
  import keypad_pkg::*;
#(
  parameter logic [3:0] BSP_KEY = KEY_BSP,
  parameter logic [3:0] CLR_KEY = KEY_CLR,
  parameter logic [3:0] ENT_KEY = KEY_ENT
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [3:0]  i_Num,
  input  logic        i_fDone,
  output logic [15:0] o_Bcd,
  output logic [2:0]  o_Count,
  output logic [15:0] o_Value,
  output logic [13:0] o_Bin,
  output logic        o_fValid,
  output logic        o_fErr
);

  entry_state_t state, state_n;
  logic [15:0]  bcd_n, value_n;
  logic [2:0]   count_n;
  logic         valid_n, err_n;
  logic         done_q;
  logic         key_event;

  // done_q resets high so a key held through reset release is not seen as a new press.
  assign key_event = i_fDone & ~done_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state    <= S_EMPTY;
      done_q   <= 1'b1;
      o_Bcd    <= '0;
      o_Count  <= '0;
      o_Value  <= '0;
      o_fValid <= 1'b0;
      o_fErr   <= 1'b0;
    end else begin
      state    <= state_n;
      done_q   <= i_fDone;
      o_Bcd    <= bcd_n;
      o_Count  <= count_n;
      o_Value  <= value_n;
      o_fValid <= valid_n;
      o_fErr   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    bcd_n   = o_Bcd;
    count_n = o_Count;
    value_n = o_Value;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (key_event) begin
      if (i_Num == CLR_KEY) begin
        bcd_n   = '0;
        count_n = '0;
        state_n = S_EMPTY;
      end else if (i_Num == ENT_KEY) begin
        if (state == S_EMPTY) begin
          err_n = 1'b1;
        end else begin
          value_n = o_Bcd;
          valid_n = 1'b1;
          bcd_n   = '0;
          count_n = '0;
          state_n = S_EMPTY;
        end
      end else if (i_Num == BSP_KEY) begin
        if (state == S_EMPTY) begin
          err_n = 1'b1;
        end else begin
          bcd_n   = {4'h0, o_Bcd[15:4]};
          count_n = o_Count - 3'd1;
          state_n = (o_Count == 3'd1) ? S_EMPTY : S_ENTRY;
        end
      end else if (i_Num <= 4'd9) begin
        if (state == S_FULL) begin
          err_n = 1'b1;
        end else begin
          bcd_n   = {o_Bcd[11:0], i_Num};
          count_n = o_Count + 3'd1;
          state_n = (o_Count == 3'(DIGITS - 1)) ? S_FULL : S_ENTRY;
        end
      end
    end
  end

  bcd4_to_bin u_bcd4_to_bin (
    .bcd (o_Value),
    .bin (o_Bin)
  );

endmodule

// File: doc/key_entry_buffer.md
KEY_ENTRY_BUFFER -- requirements
Module: key_entry_buffer

Interface
REQ-001 SHALL have parameter BSP_KEY, default 4'hA, meaning the key code for backspace.
REQ-002 SHALL have parameter CLR_KEY, default 4'hE, meaning the key code for clear-all.
REQ-003 SHALL have parameter ENT_KEY, default 4'hF, meaning the key code for enter/commit.
REQ-004 SHALL have port i_Clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port i_Rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_Num, input, 4 bits: the key code from the keypad scanner.
REQ-007 SHALL have port i_fDone, input, 1 bit: the keypad scanner's key-valid level; it is high while a key is held.
REQ-008 SHALL have port o_Bcd, output, 16 bits: the live entry as 4 BCD digits, with the newest digit in [3:0].
REQ-009 SHALL have port o_Count, output, 3 bits: the number of digits entered (0..4).
REQ-010 SHALL have port o_Value, output, 16 bits: the last committed entry in BCD.
REQ-011 SHALL have port o_Bin, output, 14 bits: the binary equivalent of o_Value (0..9999).
REQ-012 SHALL have port o_fValid, output, 1 bit: a one-cycle pulse on commit.
REQ-013 SHALL have port o_fErr, output, 1 bit: a one-cycle pulse on a rejected key.

Function
REQ-014 A key event SHALL be defined as i_fDone sampled 1 on the current edge and 0 on the previous edge; a held key SHALL yield exactly one event.
REQ-015 i_Num SHALL be sampled on the event edge; o_Bcd, o_Count, o_fValid and o_fErr SHALL update at that same edge (1-cycle latency from the sampled rise).
REQ-016 The FSM SHALL have states S_EMPTY (count 0), S_ENTRY (count 1..3) and S_FULL (count 4); the state SHALL be consistent with o_Count at all times.
REQ-017 Digit keys 0..9: o_Bcd <= {o_Bcd[11:0], i_Num} and count +1; S_EMPTY->S_ENTRY, S_ENTRY->S_ENTRY or S_FULL.
REQ-018 A digit key in S_FULL SHALL be ignored (buffer unchanged) and o_fErr SHALL pulse.
REQ-019 BSP_KEY: o_Bcd <= {4'h0, o_Bcd[15:4]} and count -1; in S_EMPTY it SHALL leave the buffer unchanged and pulse o_fErr.
REQ-020 CLR_KEY: o_Bcd <= 0, count <= 0, go to S_EMPTY; it is valid in any state and never pulses o_fErr.
REQ-021 ENT_KEY in S_ENTRY or S_FULL: o_Value <= o_Bcd, o_fValid pulses 1 cycle, buffer cleared, go to S_EMPTY.
REQ-022 ENT_KEY in S_EMPTY: o_Value unchanged, no o_fValid, o_fErr pulses.
REQ-023 Other codes (not a digit, BSP_KEY, CLR_KEY or ENT_KEY; 4'hB..4'hD at defaults) SHALL be ignored silently.
REQ-024 o_Bin SHALL equal d3*1000 + d2*100 + d1*10 + d0 of o_Value; it SHALL be combinational from registered o_Value, so it is valid in the same cycle as o_fValid.
REQ-025 o_fValid and o_fErr SHALL never be high together and SHALL never be high for more than 1 cycle per event.

Reset
REQ-026 While i_Rst=1 at an edge: o_Bcd=0, o_Count=0, o_Value=0, o_Bin=0, o_fValid=0, o_fErr=0, state S_EMPTY.
REQ-027 The previous-i_fDone register SHALL reset to 1, so a key still held across reset release produces no event.
REQ-028 Reset SHALL take priority over a coincident key event; reset mid-entry SHALL discard the partial entry and the prior o_Value.

Structure
REQ-029 The state encodings, the default key codes and the digit count (4) SHALL reside in a shared package keypad_pkg, also used by the keypad scanner.
REQ-030 The BCD-to-binary conversion SHALL be a separate combinational sub-module bcd4_to_bin (16-bit in, 14-bit out).

Verification
REQ-031 Reset, then keys 1,2,3,F (each i_fDone high for 5 cycles) -> o_Bcd 16'h0123 before F; after F: o_Value=16'h0123, o_Bin=123, o_fValid high 1 cycle, o_Count=0.
REQ-032 Keys 9,8,7,6,5 -> o_Bcd=16'h9876, o_Count=4, o_fErr pulses once on the 5; then A -> o_Bcd=16'h0987, o_Count=3.
REQ-033 i_fDone held high for 1000 cycles with i_Num=4'h7 -> exactly one digit accepted (o_Bcd=16'h0007).
REQ-034 Keys F and A in S_EMPTY -> o_fErr pulses twice, o_Value unchanged, no o_fValid; key C -> no pulse, no change.
REQ-035 Keys 4,2 then E -> o_Bcd=0, o_Count=0; then 9,9,9,9,F -> o_Bin=9999.
REQ-036 i_Rst asserted for 1 cycle after keys 5,5 with i_fDone still high -> all outputs 0; the held key is not re-entered after reset release.
